// File: rtl/frame_align_pkg.sv
// Shared definitions for the dynamic frame aligner: state encoding,
// default aligned word and the slip budget for one alignment attempt.
package frame_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_VERIFY,
    ST_LOCKED,
    ST_FAIL
  } state_e;

  localparam logic [7:0] DEFAULT_TARGET = 8'hf0;
  localparam int         MAX_SLIPS      = 8;

  // slip_count sticks at 15 instead of wrapping
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Down-counter giving the deserializer time to settle after a bit slip.
// start loads WAIT_TIME; done is high in the last settle cycle.
module settle_timer #(
  parameter int WAIT_TIME = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clr,
  output logic done
);

  localparam int CW = $clog2(WAIT_TIME + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (start) begin
      count_d = CW'(WAIT_TIME);
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == CW'(1));

endmodule

// File: rtl/frame_align_dynamic.sv
// Dynamic word aligner: slips the ISERDESE2 until the frame word matches
// TARGET for STABLE_COUNT cycles, and realigns after LOSS_COUNT misses.
module frame_align_dynamic
  import frame_align_pkg::*;
#(
  parameter logic [7:0] TARGET       = DEFAULT_TARGET,
  parameter int         WAIT_TIME    = 5,
  parameter int         STABLE_COUNT = 16,
  parameter int         LOSS_COUNT   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN,
  input  logic [7:0] frame,
  output logic       BS,
  output logic       locked,
  output logic       fail,
  output logic [3:0] slip_count
);

  localparam int MW = $clog2(STABLE_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam int AW = $clog2(MAX_SLIPS + 1);

  state_e        state_q, state_d;
  logic [MW-1:0] match_q, match_d;
  logic [LW-1:0] loss_q, loss_d;
  logic [AW-1:0] att_q, att_d;
  logic [3:0]    slip_count_q, slip_count_d;
  logic          bs_q, locked_q, fail_q;
  logic          timer_start, timer_clr, timer_done;
  logic          is_match;

  settle_timer #(.WAIT_TIME(WAIT_TIME)) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .start (timer_start),
    .clr   (timer_clr),
    .done  (timer_done)
  );

  assign is_match = (frame == TARGET);

  always_comb begin
    state_d      = state_q;
    match_d      = match_q;
    loss_d       = loss_q;
    att_d        = att_q;
    slip_count_d = slip_count_q;
    timer_start  = 1'b0;
    timer_clr    = 1'b0;
    // EN low overrides everything, including a slip about to be issued
    if (!EN) begin
      state_d   = ST_IDLE;
      match_d   = '0;
      loss_d    = '0;
      att_d     = '0;
      timer_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          slip_count_d = '0;
          att_d        = '0;
          timer_start  = 1'b1;
          state_d      = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (timer_done) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (is_match) begin
            match_d = MW'(1);
            state_d = ST_VERIFY;
          end else if (att_q == AW'(MAX_SLIPS)) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_SLIP;
          end
        end
        ST_SLIP: begin
          slip_count_d = sat_inc4(slip_count_q);
          att_d        = att_q + AW'(1);
          timer_start  = 1'b1;
          state_d      = ST_SETTLE;
        end
        ST_VERIFY: begin
          if (is_match) begin
            match_d = match_q + MW'(1);
            if (match_q + MW'(1) == MW'(STABLE_COUNT)) begin
              loss_d  = '0;
              state_d = ST_LOCKED;
            end
          end else begin
            match_d = '0;
            state_d = ST_SLIP;
          end
        end
        ST_LOCKED: begin
          if (is_match) begin
            loss_d = '0;
          end else if (loss_q + LW'(1) == LW'(LOSS_COUNT)) begin
            // a fresh attempt gets the full slip budget
            loss_d  = '0;
            match_d = '0;
            att_d   = '0;
            state_d = ST_SLIP;
          end else begin
            loss_d = loss_q + LW'(1);
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      match_q      <= '0;
      loss_q       <= '0;
      att_q        <= '0;
      slip_count_q <= '0;
      bs_q         <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_q      <= match_d;
      loss_q       <= loss_d;
      att_q        <= att_d;
      slip_count_q <= slip_count_d;
      bs_q         <= (state_d == ST_SLIP);
      locked_q     <= (state_d == ST_LOCKED);
      fail_q       <= (state_d == ST_FAIL);
    end
  end

  assign BS         = bs_q;
  assign locked     = locked_q;
  assign fail       = fail_q;
  assign slip_count = slip_count_q;

endmodule

// File: tb/tb_frame_align_dynamic.sv
// Directed bench for frame_align_dynamic with a rotating-frame deserializer
// model: each BS pulse rotates the frame one step toward alignment.
module tb_frame_align_dynamic;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       EN    = 1'b0;
  logic [7:0] frame;
  logic       BS;
  logic       locked;
  logic       fail;
  logic [3:0] slip_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_align_dynamic #(
    .TARGET       (8'hf0),
    .WAIT_TIME    (5),
    .STABLE_COUNT (16),
    .LOSS_COUNT   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .EN         (EN),
    .frame      (frame),
    .BS         (BS),
    .locked     (locked),
    .fail       (fail),
    .slip_count (slip_count)
  );

  // Deserializer model: misrotation = base_off - slips taken
  logic       stuck      = 1'b0;
  logic [2:0] base_off   = 3'd0;
  logic [2:0] slips_seen = 3'd0;
  logic [2:0] offset;

  function automatic logic [7:0] rotl(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  assign offset = base_off - slips_seen;
  assign frame  = stuck ? 8'h00 : rotl(8'hf0, offset);

  always @(posedge clk) begin
    if (BS) slips_seen <= slips_seen + 3'd1;
  end

  // Pulse monitor: cycle stamps of every BS rising sample
  int   cyc   = 0;
  int   wide  = 0;
  int   bs_cyc[$];
  logic bs_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (BS) begin
      if (bs_prev) wide++;
      else bs_cyc.push_back(cyc);
    end
    bs_prev = BS;
  end

  function automatic int pulse_at(input int k);
    if (k < bs_cyc.size()) return bs_cyc[k];
    return -1000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("check %s: got %0d ok", tag, obs);
    end
  endtask

  task automatic set_off(input logic [2:0] o);
    base_off = slips_seen + o;
  endtask

  // sel: 0 = locked, 1 = fail, 2 = BS; n = negedges waited (max_cyc on timeout)
  task automatic wait_sig(input int sel, input int max_cyc, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if ((sel == 0 && locked) || (sel == 1 && fail) || (sel == 2 && BS) || n >= max_cyc) break;
    end
  endtask

  int n, c0, n0;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_bs", BS, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fail", fail, 0);
    chk("rst_slip_count", slip_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // already aligned: no slips, lock after WAIT_TIME+1+16
    set_off(3'd0);
    c0 = cyc; n0 = bs_cyc.size();
    EN = 1'b1;
    wait_sig(0, 100, n);
    chk("aligned_lock_latency", n, 22);
    chk("aligned_pulses", bs_cyc.size() - n0, 0);
    chk("aligned_slip_count", slip_count, 0);
    EN = 1'b0;
    @(negedge clk);
    chk("aligned_en_off_locked", locked, 0);
    repeat (2) @(negedge clk);

    // rotated by 3: three pulses 7 cycles apart
    set_off(3'd3);
    c0 = cyc; n0 = bs_cyc.size();
    EN = 1'b1;
    wait_sig(0, 200, n);
    chk("rot3_lock_latency", n, 43);
    chk("rot3_pulses", bs_cyc.size() - n0, 3);
    chk("rot3_first_bs", pulse_at(n0) - c0, 7);
    chk("rot3_gap1", pulse_at(n0 + 1) - pulse_at(n0), 7);
    chk("rot3_gap2", pulse_at(n0 + 2) - pulse_at(n0 + 1), 7);
    chk("rot3_slip_count", slip_count, 3);
    EN = 1'b0;
    repeat (2) @(negedge clk);

    // stuck frame: eight slips then fail
    stuck = 1'b1;
    c0 = cyc; n0 = bs_cyc.size();
    EN = 1'b1;
    wait_sig(1, 300, n);
    chk("stuck_fail_latency", n, 63);
    chk("stuck_pulses", bs_cyc.size() - n0, 8);
    chk("stuck_locked", locked, 0);
    chk("stuck_slip_count", slip_count, 8);
    repeat (5) @(negedge clk);
    chk("stuck_fail_held", fail, 1);
    chk("stuck_no_more_bs", bs_cyc.size() - n0, 8);
    EN = 1'b0;
    @(negedge clk);
    chk("stuck_en_off_fail", fail, 0);
    stuck = 1'b0;
    repeat (2) @(negedge clk);

    // loss of lock: 3 misses tolerated, 4 force one realigning slip
    set_off(3'd0);
    EN = 1'b1;
    wait_sig(0, 100, n);
    chk("loss_initial_lock", n, 22);
    n0 = bs_cyc.size();
    set_off(3'd1);
    repeat (3) @(negedge clk);
    set_off(3'd0);
    repeat (4) @(negedge clk);
    chk("loss3_locked", locked, 1);
    chk("loss3_pulses", bs_cyc.size() - n0, 0);
    set_off(3'd1);
    repeat (4) @(negedge clk);
    chk("loss4_locked", locked, 0);
    chk("loss4_bs", BS, 1);
    wait_sig(0, 100, n);
    chk("loss4_relock_latency", n, 22);
    chk("loss4_pulses", bs_cyc.size() - n0, 1);
    chk("loss4_slip_count", slip_count, 1);
    EN = 1'b0;
    repeat (2) @(negedge clk);

    // reset during a BS pulse
    set_off(3'd3);
    EN = 1'b1;
    wait_sig(2, 50, n);
    chk("rstbs_first_bs", n, 7);
    rst_n = 1'b0;
    #1;
    chk("rstbs_bs_async", BS, 0);
    chk("rstbs_locked", locked, 0);
    chk("rstbs_fail", fail, 0);
    chk("rstbs_slip_count", slip_count, 0);
    @(negedge clk);
    c0 = cyc; n0 = bs_cyc.size();
    rst_n = 1'b1;
    wait_sig(2, 50, n);
    chk("rstbs_restart_bs", n, 7);
    EN = 1'b0;
    repeat (2) @(negedge clk);

    // EN dropped during VERIFY, then restarted
    set_off(3'd3);
    EN = 1'b1;
    repeat (35) @(negedge clk);
    chk("verify_slip_count", slip_count, 3);
    EN = 1'b0;
    n0 = bs_cyc.size();
    repeat (10) @(negedge clk);
    chk("verify_off_locked", locked, 0);
    chk("verify_off_pulses", bs_cyc.size() - n0, 0);
    chk("verify_off_slip_hold", slip_count, 3);
    EN = 1'b1;
    @(negedge clk);
    chk("verify_restart_slip_clr", slip_count, 0);
    wait_sig(0, 100, n);
    chk("verify_restart_lock", n + 1, 22);
    chk("verify_restart_pulses", bs_cyc.size() - n0, 0);
    EN = 1'b0;
    @(negedge clk);

    chk("bs_single_cycle", wide, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_align_dynamic.md
FRAME_ALIGN_DYNAMIC -- requirements
Module: frame_align_dynamic

Interface
REQ-001 SHALL have parameter TARGET, default 8'hf0: aligned frame word.
REQ-002 SHALL have parameter WAIT_TIME, default 5: settle cycles after each slip before the frame is compared.
REQ-003 SHALL have parameter STABLE_COUNT, default 16: consecutive matches required to declare lock.
REQ-004 SHALL have parameter LOSS_COUNT, default 4: consecutive mismatches in LOCKED that force realignment.
REQ-005 SHALL have port clk, input, 1: deserializer divided clock; the only clock.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port EN, input, 1: alignment enable, driven by the static bit-slip stage.
REQ-008 SHALL have port frame, input, 8: deserialized ADC frame word, synchronous to clk.
REQ-009 SHALL have port BS, output, 1: registered one-cycle bit-slip pulse to the ISERDESE2.
REQ-010 SHALL have port locked, output, 1: frame aligned and stable.
REQ-011 SHALL have port fail, output, 1: no alignment found within 8 slips.
REQ-012 SHALL have port slip_count, output, 4: slips issued since EN rose; saturates at 15.

Function
REQ-013 SHALL implement the states IDLE, SETTLE, CHECK, SLIP, VERIFY, LOCKED and FAIL.
REQ-014 In IDLE, BS, locked and fail SHALL be 0; on EN=1 the block SHALL clear slip_count and the settle timer and go to SETTLE.
REQ-015 SETTLE SHALL wait exactly WAIT_TIME clk cycles, then go to CHECK.
REQ-016 CHECK SHALL go to VERIFY with the match count set to 1 when frame==TARGET.
REQ-017 CHECK SHALL go to FAIL when frame!=TARGET and 8 slips have been issued in the current attempt.
REQ-018 CHECK SHALL go to SLIP in all other mismatch cases.
REQ-019 SLIP SHALL assert BS for exactly one cycle, increment slip_count (saturating) and the per-attempt slip counter, then go to SETTLE.
REQ-020 VERIFY SHALL increment the match count on each frame==TARGET cycle and go to LOCKED when the count reaches STABLE_COUNT.
REQ-021 Any mismatch in VERIFY SHALL clear the match count and go to SLIP.
REQ-022 In LOCKED, locked SHALL be 1 and each mismatch SHALL increment the loss counter; a match SHALL clear it.
REQ-023 When the loss counter reaches LOSS_COUNT, the block SHALL deassert locked on the next cycle, clear the per-attempt slip counter and go to SLIP.
REQ-024 FAIL SHALL hold fail=1 and BS=0 until EN deasserts.
REQ-025 EN=0 in any state SHALL force IDLE on the next edge and clear locked, fail, BS and all internal counters; slip_count SHALL hold its last value until EN rises again.
REQ-026 If EN falls in the same cycle that BS would be issued, EN SHALL win: no pulse is issued.
REQ-027 BS SHALL be low for at least WAIT_TIME+1 cycles between any two pulses.
REQ-028 The latency from EN rising to the first possible BS pulse SHALL be WAIT_TIME+2 cycles.
REQ-029 All counters SHALL be sized to hold their parameter value without wrap-around.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE and set BS=0, locked=0, fail=0, slip_count=0 and every internal counter to 0.
REQ-031 Release of rst_n SHALL be taken synchronously; no BS pulse SHALL be issued in the first cycle after release.
REQ-032 Reset asserted mid-slip SHALL truncate the BS pulse immediately.

Structure
REQ-033 Package frame_align_pkg SHALL hold the state enumeration, the default TARGET (8'hf0) and the maximum slips per attempt (8).
REQ-034 The WAIT_TIME settle counter SHALL be a sub-module named settle_timer, with inputs start and clk/rst_n and output done.

Verification
REQ-035 Frame model rotated by 3 bits, EN rises -> exactly 3 BS pulses each 7 cycles apart, locked=1 16 cycles after the final CHECK, slip_count=3.
REQ-036 Frame already 8'hf0 at EN -> no BS pulse, locked=1 after WAIT_TIME+1+16 cycles, slip_count=0.
REQ-037 Frame stuck at 8'h00 -> 8 BS pulses, then fail=1 with locked=0; EN low -> fail=0 on the next cycle.
REQ-038 Locked, then 4 consecutive bad frames -> locked falls, one BS pulse, relock after recovery; 3 bad frames followed by a good one -> locked stays 1.
REQ-039 rst_n pulsed low during a BS-high cycle -> BS=0 asynchronously, all outputs 0, state IDLE.
REQ-040 EN dropped during VERIFY -> IDLE next cycle; re-raising EN restarts with slip_count=0.
